sc_statemachinelanes: RTL and testbench

Multi-lane background scheduler for the Frogger playfield. It replaces the single-lane background state machine with one FSM that drives `LANES` independent background shift registers. Each lane has its own speed divider (period in base ticks) and its own shift direction. The block sits between the base game timer, which supplies the active-low tick and consumes the count-enable, and the lane shift registers, which consume the 2-bit shift selection codes. It also adds game restart and pause handling.

---
 rtl/sc_statemachinelanes.sv | 133 +++++++++++++
 tb/tb_sc_statemachinelanes.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sc_statemachinelanes.sv
`default_nettype none
// ============================================================================
// Module   : sc_statemachinelanes
// Summary  : One FSM that schedules shifts for LANES background lanes, each
//            with its own tick divider and direction. Adds start/pause control.
// Revision : 1.0
// ============================================================================
module sc_statemachinelanes #(
    parameter int LANES        = 4,
    parameter int PERIOD_WIDTH = 4
) (
    input  logic                            SC_STATEMACHINELANES_CLOCK_50,
    input  logic                            SC_STATEMACHINELANES_RESET_InHigh,
    input  logic                            SC_STATEMACHINELANES_startGame_InLow,
    input  logic                            SC_STATEMACHINELANES_pause_InLow,
    input  logic                            SC_STATEMACHINELANES_T0_InLow,
    input  logic [LANES*PERIOD_WIDTH-1:0]   SC_STATEMACHINELANES_period_InBus,
    input  logic [LANES-1:0]                SC_STATEMACHINELANES_direction_InBus,
    output logic [2*LANES-1:0]              SC_STATEMACHINELANES_shiftselection_OutBus,
    output logic                            SC_STATEMACHINELANES_upcount_out,
    output logic                            SC_STATEMACHINELANES_running_Out
);

    typedef enum logic [2:0] {
        S_RESET_0 = 3'd0,
        S_START_0 = 3'd1,
        S_CHECK_0 = 3'd2,
        S_INIT_0  = 3'd3,
        S_CHECK_1 = 3'd4,
        S_RUN_0   = 3'd5,
        S_SHIFT_0 = 3'd6,
        S_PAUSE_0 = 3'd7
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] c_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    logic clk;
    logic rst;
    logic w_start_n;
    logic w_pause_n;
    logic w_t0_n;

    assign clk       = SC_STATEMACHINELANES_CLOCK_50;
    assign rst       = SC_STATEMACHINELANES_RESET_InHigh;
    assign w_start_n = SC_STATEMACHINELANES_startGame_InLow;
    assign w_pause_n = SC_STATEMACHINELANES_pause_InLow;
    assign w_t0_n    = SC_STATEMACHINELANES_T0_InLow;

    state_t                  r_state;
    state_t                  w_next;
    logic [PERIOD_WIDTH-1:0] r_cnt    [LANES];
    logic [PERIOD_WIDTH-1:0] r_per    [LANES];
    logic [LANES-1:0]        r_dir;
    logic [PERIOD_WIDTH-1:0] w_per_in [LANES];
    logic [PERIOD_WIDTH-1:0] w_reload [LANES];
    logic [LANES-1:0]        w_fire;

    // A lane fires in SHIFT_0 when it is enabled and its countdown has expired.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_per_in[i] = SC_STATEMACHINELANES_period_InBus[i*PERIOD_WIDTH +: PERIOD_WIDTH];
        assign w_reload[i] = (w_per_in[i] == '0) ? '0 : (w_per_in[i] - c_ONE);
        assign w_fire[i]   = (r_per[i] != '0) && (r_cnt[i] == '0);
        assign SC_STATEMACHINELANES_shiftselection_OutBus[2*i +: 2] =
            (r_state == S_INIT_0)                ? 2'b00 :
            ((r_state == S_SHIFT_0) && w_fire[i]) ? (r_dir[i] ? 2'b01 : 2'b10) :
                                                   2'b11;
    end

    assign SC_STATEMACHINELANES_upcount_out  = (r_state != S_RUN_0);
    assign SC_STATEMACHINELANES_running_Out  = (r_state == S_RUN_0) || (r_state == S_SHIFT_0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RESET_0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET_0: w_next = S_START_0;
            S_START_0: w_next = S_CHECK_0;
            S_CHECK_0: if (!w_start_n) w_next = S_INIT_0;
            S_INIT_0:  w_next = S_CHECK_1;
            // Waiting for release keeps a held start button from re-triggering INIT.
            S_CHECK_1: if (w_start_n) w_next = S_RUN_0;
            S_RUN_0: begin
                if (!w_start_n)      w_next = S_INIT_0;
                else if (!w_pause_n) w_next = S_PAUSE_0;
                else if (!w_t0_n)    w_next = S_SHIFT_0;
            end
            S_SHIFT_0: w_next = S_RUN_0;
            S_PAUSE_0: begin
                if (!w_start_n)     w_next = S_INIT_0;
                else if (w_pause_n) w_next = S_RUN_0;
            end
            default:   w_next = S_CHECK_0;
        endcase
    end

    // Lane registers update on leaving INIT_0 (full load) or SHIFT_0 (count/reload).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_cnt[i] <= '0;
                r_per[i] <= '0;
            end
        end else if (r_state == S_INIT_0) begin
            r_dir <= SC_STATEMACHINELANES_direction_InBus;
            for (int i = 0; i < LANES; i++) begin
                r_per[i] <= w_per_in[i];
                r_cnt[i] <= w_reload[i];
            end
        end else if (r_state == S_SHIFT_0) begin
            for (int i = 0; i < LANES; i++) begin
                if (r_per[i] == '0) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == '0) begin
                    r_per[i] <= w_per_in[i];
                    r_cnt[i] <= w_reload[i];
                    r_dir[i] <= SC_STATEMACHINELANES_direction_InBus[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] - c_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_statemachinelanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_statemachinelanes
// Summary  : Scoreboard bench for sc_statemachinelanes (LANES=4, width 4).
// Revision : 1.0
// ============================================================================
module tb_sc_statemachinelanes;

    logic        clk;
    logic        rst;
    logic        start_n;
    logic        pause_n;
    logic        t0_n;
    logic [15:0] period;
    logic [3:0]  dir;
    logic [7:0]  shsel;
    logic        upc;
    logic        run;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [7:0] sel;
        logic       upc;
        logic       run;
    } exp_t;

    exp_t sb[$];

    localparam logic [7:0] c_HOLD = 8'hFF;
    localparam logic [7:0] c_LOAD = 8'h00;

    sc_statemachinelanes #(
        .LANES        (4),
        .PERIOD_WIDTH (4)
    ) u_dut (
        .SC_STATEMACHINELANES_CLOCK_50             (clk),
        .SC_STATEMACHINELANES_RESET_InHigh         (rst),
        .SC_STATEMACHINELANES_startGame_InLow      (start_n),
        .SC_STATEMACHINELANES_pause_InLow          (pause_n),
        .SC_STATEMACHINELANES_T0_InLow             (t0_n),
        .SC_STATEMACHINELANES_period_InBus         (period),
        .SC_STATEMACHINELANES_direction_InBus      (dir),
        .SC_STATEMACHINELANES_shiftselection_OutBus(shsel),
        .SC_STATEMACHINELANES_upcount_out          (upc),
        .SC_STATEMACHINELANES_running_Out          (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected SHIFT_0 codes for tick k with P={1,2,3,0}, dir={L,R,L,R};
    // p1_fast means lane1 has switched to period 1.
    function automatic logic [7:0] exp_shift(input int k, input bit p1_fast);
        logic [7:0] s;
        s      = 8'hFF;
        s[1:0] = 2'b01;
        if (p1_fast || (k % 2 == 0)) s[3:2] = 2'b10;
        if (k % 3 == 0)              s[5:4] = 2'b01;
        return s;
    endfunction

    // Push the outputs expected after the next edge, then clock and compare.
    task automatic cyc(input string tag, input logic [7:0] sel, input logic u, input logic r);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.upc = u;
        e.run = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".sel"}, {24'd0, shsel}, {24'd0, e.sel});
            chk({e.tag, ".upc"}, {31'd0, upc},   {31'd0, e.upc});
            chk({e.tag, ".run"}, {31'd0, run},   {31'd0, e.run});
        end
    endtask

    task automatic tick(input int k, input bit p1_fast);
        t0_n = 1'b0;
        cyc($sformatf("tick%0d", k), exp_shift(k, p1_fast), 1'b1, 1'b1);
        t0_n = 1'b1;
        repeat (3) cyc("run_gap", c_HOLD, 1'b0, 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        start_n = 1'b1;
        pause_n = 1'b1;
        t0_n    = 1'b1;
        period  = 16'h0321;
        dir     = 4'b0101;

        repeat (3) cyc("reset", c_HOLD, 1'b1, 1'b0);
        rst = 1'b0;
        cyc("start0", c_HOLD, 1'b1, 1'b0);
        cyc("check0", c_HOLD, 1'b1, 1'b0);
        t0_n = 1'b0;
        cyc("check0_t0", c_HOLD, 1'b1, 1'b0);
        t0_n = 1'b1;

        start_n = 1'b0;
        cyc("init", c_LOAD, 1'b1, 1'b0);
        repeat (4) cyc("check1_held", c_HOLD, 1'b1, 1'b0);
        start_n = 1'b1;
        cyc("run_enter", c_HOLD, 1'b0, 1'b1);
        cyc("run", c_HOLD, 1'b0, 1'b1);

        for (int k = 1; k <= 6; k++) tick(k, 1'b0);

        pause_n = 1'b0;
        t0_n    = 1'b0;
        cyc("pause_with_tick", c_HOLD, 1'b1, 1'b0);
        t0_n = 1'b1;
        cyc("paused", c_HOLD, 1'b1, 1'b0);
        t0_n = 1'b0;
        cyc("paused_tick", c_HOLD, 1'b1, 1'b0);
        t0_n = 1'b1;
        cyc("paused", c_HOLD, 1'b1, 1'b0);
        pause_n = 1'b1;
        cyc("resume", c_HOLD, 1'b0, 1'b1);
        cyc("run", c_HOLD, 1'b0, 1'b1);
        for (int k = 7; k <= 9; k++) tick(k, 1'b0);

        period = 16'h0311;
        for (int k = 10; k <= 12; k++) tick(k, 1'b1);

        t0_n = 1'b0;
        cyc("held_tick13", exp_shift(13, 1'b1), 1'b1, 1'b1);
        cyc("held_gap", c_HOLD, 1'b0, 1'b1);
        cyc("held_tick14", exp_shift(14, 1'b1), 1'b1, 1'b1);
        t0_n = 1'b1;
        cyc("run", c_HOLD, 1'b0, 1'b1);
        cyc("run", c_HOLD, 1'b0, 1'b1);

        t0_n = 1'b0;
        cyc("tick15", exp_shift(15, 1'b1), 1'b1, 1'b1);
        t0_n    = 1'b1;
        start_n = 1'b0;
        cyc("restart_shift_done", c_HOLD, 1'b0, 1'b1);
        period = 16'h0111;
        cyc("restart_init", c_LOAD, 1'b1, 1'b0);
        start_n = 1'b1;
        cyc("restart_check1", c_HOLD, 1'b1, 1'b0);
        cyc("restart_run", c_HOLD, 1'b0, 1'b1);
        t0_n = 1'b0;
        cyc("restart_tick", 8'hD9, 1'b1, 1'b1);
        t0_n = 1'b1;
        cyc("run", c_HOLD, 1'b0, 1'b1);

        start_n = 1'b0;
        pause_n = 1'b0;
        cyc("start_beats_pause", c_LOAD, 1'b1, 1'b0);
        start_n = 1'b1;
        pause_n = 1'b1;
        cyc("check1", c_HOLD, 1'b1, 1'b0);
        cyc("run", c_HOLD, 1'b0, 1'b1);

        t0_n = 1'b0;
        cyc("pre_reset_tick", 8'hD9, 1'b1, 1'b1);
        t0_n = 1'b1;
        rst  = 1'b1;
        repeat (3) cyc("reset_mid_shift", c_HOLD, 1'b1, 1'b0);
        rst = 1'b0;
        repeat (3) cyc("post_reset_idle", c_HOLD, 1'b1, 1'b0);
        start_n = 1'b0;
        cyc("init2", c_LOAD, 1'b1, 1'b0);
        start_n = 1'b1;
        cyc("check1_2", c_HOLD, 1'b1, 1'b0);
        cyc("run2", c_HOLD, 1'b0, 1'b1);
        t0_n = 1'b0;
        cyc("tick_after_reset", 8'hD9, 1'b1, 1'b1);
        t0_n = 1'b1;
        cyc("run2", c_HOLD, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
